// File: rtl/prim_ram_1p_scrub.sv
// ECC scrubber: walks every RAM word once per start, writes back corrected
// words and counts correctable / uncorrectable read events.
module prim_ram_1p_scrub #(
  parameter int Depth    = 512,
  parameter int Width    = 32,
  parameter int CntWidth = 16,
  localparam int Aw      = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                req_o,
  input  logic                gnt_i,
  output logic                write_o,
  output logic [Aw-1:0]       addr_o,
  output logic [Width-1:0]    wdata_o,
  output logic [Width-1:0]    wmask_o,
  input  logic                rvalid_i,
  input  logic [Width-1:0]    rdata_i,
  input  logic [1:0]          rerror_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CntWidth-1:0] corr_cnt_o,
  output logic [CntWidth-1:0] uncorr_cnt_o,
  output logic [Aw-1:0]       uncorr_addr_o,
  output logic                uncorr_vld_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WB_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e              state_q, state_d;
  logic [Aw-1:0]       ptr_q, ptr_d;
  logic [Width-1:0]    wb_q, wb_d;
  logic [CntWidth-1:0] corr_q, corr_d, uncorr_q, uncorr_d;
  logic [Aw-1:0]       uaddr_q, uaddr_d;
  logic                uvld_q, uvld_d;
  logic                advance;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wb_q     <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      uaddr_q  <= '0;
      uvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wb_q     <= wb_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      uaddr_q  <= uaddr_d;
      uvld_q   <= uvld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wb_d     = wb_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    uaddr_d  = uaddr_q;
    uvld_d   = uvld_q;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          corr_d   = '0;
          uncorr_d = '0;
          uaddr_d  = '0;
          uvld_d   = 1'b0;
          ptr_d    = '0;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        // A grant in the same cycle as abort still commits the read.
        if (gnt_i)        state_d = RD_WAIT;
        else if (abort_i) state_d = IDLE;
      end
      RD_WAIT: begin
        if (rvalid_i) begin
          if (rerror_i[1]) begin
            if (uncorr_q != '1) uncorr_d = uncorr_q + CntWidth'(1);
            if (!uvld_q) begin
              uaddr_d = ptr_q;
              uvld_d  = 1'b1;
            end
            advance = 1'b1;
          end else if (rerror_i[0]) begin
            if (corr_q != '1) corr_d = corr_q + CntWidth'(1);
            wb_d    = rdata_i;
            state_d = WB_REQ;
          end else begin
            advance = 1'b1;
          end
        end
      end
      WB_REQ: begin
        if (gnt_i) advance = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (abort_i)                 state_d = IDLE;
      else if (ptr_q == LastAddr)  state_d = DONE;
      else begin
        ptr_d   = ptr_q + Aw'(1);
        state_d = RD_REQ;
      end
    end
  end

  assign req_o         = (state_q == RD_REQ) || (state_q == WB_REQ);
  assign write_o       = (state_q == WB_REQ);
  assign addr_o        = ptr_q;
  assign wdata_o       = write_o ? wb_q : '0;
  // Full mask on every write; forced low otherwise so reset leaves all outputs at 0.
  assign wmask_o       = {Width{write_o}};
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign corr_cnt_o    = corr_q;
  assign uncorr_cnt_o  = uncorr_q;
  assign uncorr_addr_o = uaddr_q;
  assign uncorr_vld_o  = uvld_q;

endmodule

// File: tb/tb_prim_ram_1p_scrub.sv
// Scoreboard bench for prim_ram_1p_scrub: a small RAM model answers reads,
// expected transactions are queued up front and matched as the DUT issues them.
module tb_prim_ram_1p_scrub;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, gnt_i = 1'b1, rvalid_i = 1'b0;
  logic [W-1:0]  rdata_i = '0;
  logic [1:0]    rerror_i = '0;
  logic          req_o, write_o, busy_o, done_o, uncorr_vld_o;
  logic [AW-1:0] addr_o, uncorr_addr_o;
  logic [W-1:0]  wdata_o, wmask_o;
  logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;

  prim_ram_1p_scrub #(.Depth(D), .Width(W), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .req_o(req_o), .gnt_i(gnt_i), .write_o(write_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .wmask_o(wmask_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .rerror_i(rerror_i), .busy_o(busy_o), .done_o(done_o),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
    .uncorr_addr_o(uncorr_addr_o), .uncorr_vld_o(uncorr_vld_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } txn_t;

  txn_t          exp_q[$];
  logic [W-1:0]  mem [D];
  logic [1:0]    err [D];
  int            errs = 0, checks = 0;
  bit            pend = 0;
  logic [W-1:0]  pend_data = '0;
  logic [1:0]    pend_err = '0;
  int            stall_cnt = 0;
  bit            stall_rd_en = 0, stall_wb_en = 0;
  logic [AW-1:0] stall_rd_addr = '0;
  bit            prev_stall = 0;
  logic [W+AW:0] prev_sig = '0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Transaction monitor and read capture, sampled mid-cycle.
  always @(negedge clk_i) begin
    txn_t t;
    if (rst_ni && req_o) begin
      if (prev_stall) chk("hold_req", {write_o, addr_o, wdata_o}, prev_sig);
      if (gnt_i) begin
        if (exp_q.size() == 0) chk("extra_txn", {write_o, addr_o}, 0);
        else begin
          t = exp_q.pop_front();
          chk("txn_wr", write_o, t.wr);
          chk("txn_addr", addr_o, t.addr);
          if (t.wr) begin
            chk("txn_wdata", wdata_o, t.data);
            chk("txn_wmask", wmask_o, {W{1'b1}});
          end
        end
        if (!write_o) begin
          pend      = 1;
          pend_data = mem[addr_o];
          pend_err  = err[addr_o];
        end
      end
      prev_stall = !gnt_i;
      prev_sig   = {write_o, addr_o, wdata_o};
    end else begin
      prev_stall = 0;
    end
  end

  // Arbiter stalls and 1-cycle read response, driven just after the edge.
  always @(posedge clk_i) begin
    #1;
    if (stall_cnt > 0) stall_cnt--;
    else if (stall_rd_en && req_o && !write_o && addr_o == stall_rd_addr) begin
      stall_rd_en = 0;
      stall_cnt   = 4;
    end else if (stall_wb_en && req_o && write_o) begin
      stall_wb_en = 0;
      stall_cnt   = 4;
    end
    gnt_i    = (stall_cnt == 0);
    rvalid_i = pend;
    rdata_i  = pend ? pend_data : '0;
    rerror_i = pend ? pend_err : 2'b00;
    pend     = 0;
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_err();
    for (int a = 0; a < D; a++) err[a] = 2'b00;
  endtask

  task automatic plan(input int last);
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back(txn_t'{wr: 1'b0, addr: AW'(a), data: '0});
      if (err[a] == 2'b01) exp_q.push_back(txn_t'{wr: 1'b1, addr: AW'(a), data: mem[a]});
    end
  endtask

  // Pulses start and runs to idle; done_at counts edges from the start edge.
  task automatic sweep(output int done_at, output int ndone);
    int n;
    done_at = 0; ndone = 0;
    start_i = 1;
    step();
    start_i = 0;
    n = 1;
    while (busy_o && n < 300) begin
      if (done_o) begin
        ndone++;
        done_at = n;
      end
      step();
      n++;
    end
    chk("sweep_bound", busy_o, 0);
  endtask

  task automatic chk_counts(input int c, input int u, input int ua, input int uv);
    chk("corr_cnt", corr_cnt_o, c);
    chk("uncorr_cnt", uncorr_cnt_o, u);
    chk("uncorr_addr", uncorr_addr_o, ua);
    chk("uncorr_vld", uncorr_vld_o, uv);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, ndone, n;
    for (int a = 0; a < D; a++) mem[a] = 32'h1000_0000 + a * 32'h0101;
    mem[3] = 32'hDEAD_BEEF;
    clear_err();

    #2;
    chk("rst_outs", {req_o, write_o, addr_o, wdata_o, wmask_o, done_o, corr_cnt_o,
                     uncorr_cnt_o, uncorr_addr_o, uncorr_vld_o}, 0);
    chk("rst_busy", busy_o, 0);
    step();
    rst_ni = 1;
    step();

    // clean sweep
    plan(D - 1);
    sweep(done_at, ndone);
    chk("clean_ndone", ndone, 1);
    chk("clean_done_at", done_at, 17);
    chk_counts(0, 0, 0, 0);

    // single correctable word gets written back
    err[3] = 2'b01;
    plan(D - 1);
    sweep(done_at, ndone);
    chk("corr_ndone", ndone, 1);
    chk("corr_done_at", done_at, 18);
    chk_counts(1, 0, 0, 0);

    // uncorrectable words: counted, first address latched, no writes
    clear_err();
    err[2] = 2'b10; err[5] = 2'b10; err[6] = 2'b11;
    plan(D - 1);
    sweep(done_at, ndone);
    chk("unc_ndone", ndone, 1);
    chk_counts(0, 3, 2, 1);

    // grant stalls on the read of addr 1 and on the write-back
    clear_err();
    err[3] = 2'b01;
    stall_rd_addr = 3'd1; stall_rd_en = 1; stall_wb_en = 1;
    plan(D - 1);
    sweep(done_at, ndone);
    chk("stall_ndone", ndone, 1);
    chk("stall_done_at", done_at, 26);
    chk_counts(1, 0, 0, 0);

    // abort while the write-back to addr 4 waits for grant
    clear_err();
    err[4] = 2'b01;
    stall_wb_en = 1;
    plan(4);
    start_i = 1;
    step();
    start_i = 0;
    n = 0;
    while (!(req_o && write_o) && n < 100) begin step(); n++; end
    chk("abort_saw_wb", req_o && write_o, 1);
    abort_i = 1;
    n = 0; ndone = 0;
    while (busy_o && n < 100) begin
      if (done_o) ndone++;
      step();
      n++;
    end
    abort_i = 0;
    chk("abort_idle", busy_o, 0);
    chk("abort_ndone", ndone, 0);
    chk_counts(1, 0, 0, 0);

    // restart clears the counters and begins again at addr 0
    clear_err();
    plan(D - 1);
    sweep(done_at, ndone);
    chk("restart_ndone", ndone, 1);
    chk_counts(0, 0, 0, 0);

    // five correctable words saturate a 2-bit counter
    for (int a = 0; a < 5; a++) err[a] = 2'b01;
    plan(D - 1);
    sweep(done_at, ndone);
    chk("sat_ndone", ndone, 1);
    chk_counts(3, 0, 0, 0);

    // reset mid-sweep
    clear_err();
    plan(D - 1);
    start_i = 1;
    step();
    start_i = 0;
    repeat (4) step();
    chk("pre_rst_busy", busy_o, 1);
    rst_ni = 0;
    #1;
    chk("mid_rst_outs", {req_o, write_o, addr_o, wdata_o, wmask_o, done_o, corr_cnt_o,
                         uncorr_cnt_o, uncorr_addr_o, uncorr_vld_o}, 0);
    chk("mid_rst_busy", busy_o, 0);
    exp_q.delete();
    pend = 0;
    step();
    rst_ni = 1;
    step();
    chk("post_rst_busy", busy_o, 0);

    // recovery sweep after reset
    plan(D - 1);
    sweep(done_at, ndone);
    chk("recov_done_at", done_at, 17);
    chk_counts(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
